// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_t;

  localparam logic [3:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: owns last_grant and produces a one-hot grant
// that doubles as the ready handshake. Nothing is granted while reset is low.
module rr_arb2
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_alu,
  input  logic       i_req_mem,
  output logic [1:0] o_gnt
);

  grant_t r_last;
  logic   w_gnt_alu;
  logic   w_gnt_mem;

  // On a tie the side that did not win last time takes the port.
  always_comb begin
    w_gnt_alu = rst && i_req_alu && (!i_req_mem || (r_last == GNT_MEM));
    w_gnt_mem = rst && i_req_mem && (!i_req_alu || (r_last == GNT_ALU));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= GNT_MEM;
    end else if (w_gnt_alu) begin
      r_last <= GNT_ALU;
    end else if (w_gnt_mem) begin
      r_last <= GNT_MEM;
    end
  end

  assign o_gnt = {w_gnt_mem, w_gnt_alu};

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter sharing the register-file write port between ALU and load paths.
// Optional same-cycle forwarding of the staged write is enabled by defining WB_FWD_EN.
module wb_arbiter #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int REG_AW = wb_pkg::REG_AW,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              write_reg,
  output logic [REG_AW-1:0] dst_reg,
  output logic [DATA_W-1:0] dst_data,
`ifdef WB_FWD_EN
  input  logic [REG_AW-1:0] fwd_src1,
  input  logic [REG_AW-1:0] fwd_src2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
`endif
  output logic [CNT_W-1:0]  conflict_cnt
);

  import wb_pkg::*;

  logic [1:0]        w_gnt;
  logic              w_acc;
  logic [REG_AW-1:0] w_sel_reg;
  logic [DATA_W-1:0] w_sel_data;
  logic              r_write;
  logic [REG_AW-1:0] r_dst_reg;
  logic [DATA_W-1:0] r_dst_data;
  logic [CNT_W-1:0]  r_cnt;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req_alu (alu_valid),
    .i_req_mem (mem_valid),
    .o_gnt     (w_gnt)
  );

  assign alu_ready  = w_gnt[0];
  assign mem_ready  = w_gnt[1];
  assign w_acc      = |w_gnt;
  assign w_sel_reg  = w_gnt[1] ? mem_reg  : alu_reg;
  assign w_sel_data = w_gnt[1] ? mem_data : alu_data;

  // Register-0 writes are accepted and staged, but never enable the write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write    <= 1'b0;
      r_dst_reg  <= '0;
      r_dst_data <= '0;
      r_cnt      <= '0;
    end else begin
      r_write <= w_acc && (w_sel_reg != REG_AW'(REG_ZERO));
      if (w_acc) begin
        r_dst_reg  <= w_sel_reg;
        r_dst_data <= w_sel_data;
      end
      if (alu_valid && mem_valid && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign write_reg    = r_write;
  assign dst_reg      = r_dst_reg;
  assign dst_data     = r_dst_data;
  assign conflict_cnt = r_cnt;

`ifdef WB_FWD_EN
  always_comb begin
    fwd_hit1  = r_write && (r_dst_reg == fwd_src1) && (fwd_src1 != REG_AW'(REG_ZERO));
    fwd_hit2  = r_write && (r_dst_reg == fwd_src2) && (fwd_src2 != REG_AW'(REG_ZERO));
    fwd_data1 = fwd_hit1 ? r_dst_data : '0;
    fwd_data2 = fwd_hit2 ? r_dst_data : '0;
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, reset/saturation sequences and a
// randomized run against a transaction-level reference model.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_reg;
  logic [15:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_reg;
  logic [15:0] mem_data;
  logic        write_reg;
  logic [3:0]  dst_reg;
  logic [15:0] dst_data;
  logic [7:0]  conflict_cnt;
`ifdef WB_FWD_EN
  logic [3:0]  fwd_src1;
  logic [3:0]  fwd_src2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [15:0] fwd_data1;
  logic [15:0] fwd_data2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  wb_arbiter #(.DATA_W(16), .REG_AW(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_reg      (alu_reg),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_reg      (mem_reg),
    .mem_data     (mem_data),
    .write_reg    (write_reg),
    .dst_reg      (dst_reg),
    .dst_data     (dst_data),
`ifdef WB_FWD_EN
    .fwd_src1     (fwd_src1),
    .fwd_src2     (fwd_src2),
    .fwd_hit1     (fwd_hit1),
    .fwd_hit2     (fwd_hit2),
    .fwd_data1    (fwd_data1),
    .fwd_data2    (fwd_data2),
`endif
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        av;
    logic [3:0]  ar;
    logic [15:0] ad;
    logic        mv;
    logic [3:0]  mr;
    logic [15:0] md;
    logic        e_ardy;
    logic        e_mrdy;
    logic        e_we;
    logic [3:0]  e_reg;
    logic [15:0] e_data;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vt[10];

  // Reference model state: who won last, the staged write, the conflict count.
  int          m_last;
  bit          m_we;
  logic [3:0]  m_reg;
  logic [15:0] m_data;
  int          m_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                       input logic mv, input logic [3:0] mr, input logic [15:0] md);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    tick();
    rst = 1'b1;
    m_last = 1; m_we = 1'b0; m_reg = 4'd0; m_data = 16'd0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".write_reg"}, 32'(write_reg), 32'(m_we));
    check({tag, ".dst_reg"}, 32'(dst_reg), 32'(m_reg));
    check({tag, ".dst_data"}, 32'(dst_data), 32'(m_data));
    check({tag, ".conflict_cnt"}, 32'(conflict_cnt), 32'(m_cnt));
  endtask

  initial begin
    bit av, mv, win_alu, win_mem;
    logic [3:0]  ar, mr;
    logic [15:0] ad, md;

    vt[0] = '{1'b1, 4'd1, 16'hA001, 1'b1, 4'd2, 16'hB002, 1'b1, 1'b0, 1'b1, 4'd1, 16'hA001, 8'd1};
    vt[1] = '{1'b1, 4'd1, 16'hA001, 1'b1, 4'd2, 16'hB002, 1'b0, 1'b1, 1'b1, 4'd2, 16'hB002, 8'd2};
    vt[2] = '{1'b1, 4'd1, 16'hA001, 1'b1, 4'd2, 16'hB002, 1'b1, 1'b0, 1'b1, 4'd1, 16'hA001, 8'd3};
    vt[3] = '{1'b1, 4'd1, 16'hA001, 1'b1, 4'd2, 16'hB002, 1'b0, 1'b1, 1'b1, 4'd2, 16'hB002, 8'd4};
    vt[4] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd2, 16'hB002, 8'd4};
    vt[5] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd0, 16'hFFFF, 8'd4};
    vt[6] = '{1'b1, 4'd4, 16'h0044, 1'b1, 4'd6, 16'h0066, 1'b1, 1'b0, 1'b1, 4'd4, 16'h0044, 8'd5};
    vt[7] = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd3, 16'h1234, 8'd5};
    vt[8] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 16'h5678, 1'b0, 1'b1, 1'b1, 4'd3, 16'h5678, 8'd5};
    vt[9] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd3, 16'h5678, 8'd5};

`ifdef WB_FWD_EN
    fwd_src1 = 4'd0;
    fwd_src2 = 4'd0;
`endif

    // Reset with requests pending: nothing may be accepted.
    rst = 1'b0;
    drive(1'b1, 4'd9, 16'h9999, 1'b1, 4'd8, 16'h8888);
    #2;
    check("rst.alu_ready", 32'(alu_ready), 32'd0);
    check("rst.mem_ready", 32'(mem_ready), 32'd0);
    check("rst.write_reg", 32'(write_reg), 32'd0);
    check("rst.dst_reg", 32'(dst_reg), 32'd0);
    check("rst.dst_data", 32'(dst_data), 32'd0);
    check("rst.conflict_cnt", 32'(conflict_cnt), 32'd0);
    do_reset();

    // Single ALU write: one-cycle write pulse, then idle.
    drive(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'd0);
    #1;
    check("single.alu_ready", 32'(alu_ready), 32'd1);
    tick();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    check("single.write_reg", 32'(write_reg), 32'd1);
    check("single.dst_reg", 32'(dst_reg), 32'd3);
    check("single.dst_data", 32'(dst_data), 32'h1234);
    tick();
    check("single.write_reg_drop", 32'(write_reg), 32'd0);

    // Vector table from a fresh reset.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].av, vt[i].ar, vt[i].ad, vt[i].mv, vt[i].mr, vt[i].md);
      #1;
      check($sformatf("vec%0d.alu_ready", i), 32'(alu_ready), 32'(vt[i].e_ardy));
      check($sformatf("vec%0d.mem_ready", i), 32'(mem_ready), 32'(vt[i].e_mrdy));
      tick();
      check($sformatf("vec%0d.write_reg", i), 32'(write_reg), 32'(vt[i].e_we));
      check($sformatf("vec%0d.dst_reg", i), 32'(dst_reg), 32'(vt[i].e_reg));
      check($sformatf("vec%0d.dst_data", i), 32'(dst_data), 32'(vt[i].e_data));
      check($sformatf("vec%0d.conflict_cnt", i), 32'(conflict_cnt), 32'(vt[i].e_cnt));
    end

    // Saturation: 300 cycles of contention with strict alternation.
    do_reset();
    drive(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222);
    for (int i = 0; i < 300; i++) begin
      #1;
      check($sformatf("sat%0d.alu_ready", i), 32'(alu_ready), 32'((i % 2) == 0));
      tick();
    end
    check("sat.conflict_cnt", 32'(conflict_cnt), 32'hFF);
    tick();
    tick();
    check("sat.conflict_cnt_hold", 32'(conflict_cnt), 32'hFF);

    // Asynchronous reset while a write to r5 is staged.
    do_reset();
    drive(1'b1, 4'd5, 16'h0555, 1'b0, 4'd0, 16'd0);
    tick();
    check("arst.staged_we", 32'(write_reg), 32'd1);
    check("arst.staged_reg", 32'(dst_reg), 32'd5);
    drive(1'b1, 4'd1, 16'hA1A1, 1'b1, 4'd2, 16'hB2B2);
    #2;
    rst = 1'b0;
    #1;
    check("arst.write_reg", 32'(write_reg), 32'd0);
    check("arst.dst_reg", 32'(dst_reg), 32'd0);
    check("arst.dst_data", 32'(dst_data), 32'd0);
    check("arst.alu_ready", 32'(alu_ready), 32'd0);
    check("arst.mem_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst.tie_alu_ready", 32'(alu_ready), 32'd1);
    check("arst.tie_mem_ready", 32'(mem_ready), 32'd0);
    tick();
    check("arst.tie_dst_reg", 32'(dst_reg), 32'd1);
    check("arst.conflict_cnt", 32'(conflict_cnt), 32'd1);

`ifdef WB_FWD_EN
    do_reset();
    fwd_src1 = 4'd7;
    fwd_src2 = 4'd0;
    #1;
    check("fwd.idle_hit1", 32'(fwd_hit1), 32'd0);
    drive(1'b1, 4'd7, 16'hBEEF, 1'b0, 4'd0, 16'd0);
    tick();
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    check("fwd.hit1", 32'(fwd_hit1), 32'd1);
    check("fwd.data1", 32'(fwd_data1), 32'hBEEF);
    check("fwd.hit2", 32'(fwd_hit2), 32'd0);
    check("fwd.data2", 32'(fwd_data2), 32'd0);
    fwd_src2 = 4'd7;
    #1;
    check("fwd.hit2_match", 32'(fwd_hit2), 32'd1);
    drive(1'b1, 4'd0, 16'h1111, 1'b0, 4'd0, 16'd0);
    tick();
    fwd_src1 = 4'd0;
    #1;
    check("fwd.r0_hit1", 32'(fwd_hit1), 32'd0);
    drive(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      av = ($urandom_range(0, 3) != 0);
      mv = ($urandom_range(0, 3) != 0);
      ar = 4'($urandom_range(0, 15));
      mr = 4'($urandom_range(0, 15));
      ad = 16'($urandom);
      md = 16'($urandom);
      drive(av, ar, ad, mv, mr, md);
      win_alu = av && (!mv || (m_last == 1));
      win_mem = mv && !win_alu;
      #1;
      check($sformatf("rnd%0d.alu_ready", i), 32'(alu_ready), 32'(win_alu));
      check($sformatf("rnd%0d.mem_ready", i), 32'(mem_ready), 32'(win_mem));
      tick();
      if (win_alu) begin
        m_last = 0; m_we = (ar != 4'd0); m_reg = ar; m_data = ad;
      end else if (win_mem) begin
        m_last = 1; m_we = (mr != 4'd0); m_reg = mr; m_data = md;
      end else begin
        m_we = 1'b0;
      end
      if (av && mv && (m_cnt < 255)) m_cnt++;
      check_outputs($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
